// File: rtl/line_memory_responder_pkg.sv
// Shared types for the line-fill memory responder.
package line_memory_responder_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_WAIT,
    MEM_BURST,
    MEM_DONE
  } memory_state_e;

  typedef enum logic {
    MEM_OP_READ,
    MEM_OP_WRITE
  } memory_op_e;

endpackage

// File: rtl/line_memory_responder_word_array.sv
// Backing store: DEPTH x 32-bit words, one port, synchronous write, asynchronous read.
// Contents are not reset.
module memory_word_array
  import line_memory_responder_pkg::*;
#(
  parameter int DEPTH = 4096
) (
  input  logic                     i_clock,
  input  logic                     write_enable,
  input  logic [$clog2(DEPTH)-1:0] address,
  input  logic [WORD_W-1:0]        write_data,
  output logic [WORD_W-1:0]        read_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Store one word on a write strobe
  always_ff @(posedge i_clock) begin
    if (write_enable) mem[address] <= write_data;
  end

  assign read_data = mem[address];

endmodule

// File: rtl/line_memory_responder.sv
// Line-fill memory responder: accepts one line read/write, waits LATENCY cycles,
// moves one word per cycle, then pulses o_done.
// Optional feature: define MEMORY_BOUNDS_CHECK_EN to flag out-of-range addresses
// on o_error instead of wrapping modulo DEPTH.
module line_memory_responder
  import line_memory_responder_pkg::*;
#(
  parameter int WORDS   = 4,
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 3
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_read,
  input  logic                    i_write,
  input  logic [31:0]             i_address,
  input  logic [WORDS*WORD_W-1:0] i_wdata,
  output logic                    o_ready,
  output logic [WORDS*WORD_W-1:0] o_rdata,
  output logic                    o_done,
  output logic                    o_error
);

  localparam int AW = $clog2(DEPTH);
  localparam int WB = $clog2(WORDS);
  localparam int LW = AW - WB;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(LATENCY - 1);
  localparam logic [WB-1:0] WORD_LAST = WB'(WORDS - 1);

  memory_state_e                   state_q, state_d;
  memory_op_e                      op_q;
  logic [LW-1:0]                   line_q;
  logic [WORDS-1:0][WORD_W-1:0]    wline_q;
  logic [WORDS-1:0][WORD_W-1:0]    rdata_q;
  logic [WB-1:0]                   word_cnt_q;
  logic [CW-1:0]                   wait_cnt_q;
  logic                            oob_q;

  logic                            accept;
  logic                            req_oob;
  logic                            unused_addr;
  logic                            mem_we;
  logic                            rd_fill;
  logic [AW-1:0]                   mem_addr;
  logic [WORD_W-1:0]               mem_rdata;

`ifdef MEMORY_BOUNDS_CHECK_EN
  assign req_oob     = |i_address[31:AW+2];
  assign unused_addr = ^i_address[WB+1:0];
`else
  assign req_oob     = 1'b0;
  assign unused_addr = ^{i_address[31:AW+2], i_address[WB+1:0]};
`endif

  assign accept   = o_ready && (i_read || i_write);
  assign mem_addr = {line_q, word_cnt_q};

  // Next state and handshake/strobe outputs
  always_comb begin
    state_d = state_q;
    o_ready = 1'b0;
    o_done  = 1'b0;
    o_error = 1'b0;
    mem_we  = 1'b0;
    rd_fill = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        o_ready = 1'b1;
        if (i_read || i_write) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) state_d = MEM_BURST;
      end
      MEM_BURST: begin
        // Write strobe is gated by reset so an aborted burst stops cleanly.
        mem_we  = (op_q == MEM_OP_WRITE) && !oob_q && i_reset;
        rd_fill = (op_q == MEM_OP_READ) && !oob_q;
        if (word_cnt_q == WORD_LAST) state_d = MEM_DONE;
      end
      MEM_DONE: begin
        o_done  = 1'b1;
`ifdef MEMORY_BOUNDS_CHECK_EN
        o_error = oob_q;
`endif
        state_d = MEM_IDLE;
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  // State register plus latency and word counters
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q    <= MEM_IDLE;
      wait_cnt_q <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        MEM_IDLE: begin
          wait_cnt_q <= '0;
          word_cnt_q <= '0;
        end
        MEM_WAIT:  wait_cnt_q <= wait_cnt_q + CW'(1);
        MEM_BURST: word_cnt_q <= word_cnt_q + WB'(1);
        default: ;
      endcase
    end
  end

  // Capture the request at accept; read wins when both strobes are set
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      op_q    <= MEM_OP_READ;
      line_q  <= '0;
      wline_q <= '0;
      oob_q   <= 1'b0;
    end else if (accept) begin
      op_q    <= i_read ? MEM_OP_READ : MEM_OP_WRITE;
      line_q  <= i_address[AW+1:WB+2];
      wline_q <= i_wdata;
      oob_q   <= req_oob;
    end
  end

  // Read line register: cleared at accept, filled one slot per burst cycle
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      rdata_q <= '0;
    end else if (accept) begin
      rdata_q <= '0;
    end else if (rd_fill) begin
      rdata_q[word_cnt_q] <= mem_rdata;
    end
  end

  assign o_rdata = rdata_q;

  memory_word_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .i_clock      (i_clock),
    .write_enable (mem_we),
    .address      (mem_addr),
    .write_data   (wline_q[word_cnt_q]),
    .read_data    (mem_rdata)
  );

endmodule

// File: tb/tb_line_memory_responder.sv
// Directed self-checking bench for line_memory_responder (WORDS=4, DEPTH=4096, LATENCY=3).
module tb_line_memory_responder;

  localparam int EXP_LAT = 8;

  logic         clk;
  logic         rst_n;
  logic         rd;
  logic         wr;
  logic [31:0]  addr;
  logic [127:0] wdata;
  logic         ready;
  logic [127:0] rdata;
  logic         done;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;

  line_memory_responder #(
    .WORDS(4), .DEPTH(4096), .LATENCY(3)
  ) dut (
    .i_clock   (clk),
    .i_reset   (rst_n),
    .i_read    (rd),
    .i_write   (wr),
    .i_address (addr),
    .i_wdata   (wdata),
    .o_ready   (ready),
    .o_rdata   (rdata),
    .o_done    (done),
    .o_error   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request at the next negedge (responder idle), then count cycles to o_done.
  // lat = -1 if o_done never arrives; busy_rdy counts busy cycles where o_ready was seen high.
  task automatic run_req(input logic r, input logic w, input logic [31:0] a,
                         input logic [127:0] wd, input bit hold,
                         output int lat, output logic [127:0] rdat, output logic e,
                         output int busy_rdy);
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = wd;
    lat = -1; rdat = 'x; e = 1'bx; busy_rdy = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (!hold) begin rd = 1'b0; wr = 1'b0; end
      if (ready) busy_rdy++;
      if (done) begin
        lat = c; rdat = rdata; e = err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rd = 0; wr = 0; addr = 0; wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (rdata !== 128'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", rdata); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_error got %b want 0", err); end
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    int lat, br; logic [127:0] d; logic e;
    logic [127:0] line = {32'h44, 32'h33, 32'h22, 32'h11};
    run_req(1'b0, 1'b1, 32'h0000_0040, line, 1'b0, lat, d, e, br);
    n_checks++; if (lat !== EXP_LAT) begin n_fail++; $display("FAIL wr_latency got %0d want %0d", lat, EXP_LAT); end
    n_checks++; if (d !== 128'h0) begin n_fail++; $display("FAIL wr_rdata_zero got %h want 0", d); end
    n_checks++; if (br !== 0) begin n_fail++; $display("FAIL wr_ready_busy got %0d want 0", br); end
    run_req(1'b1, 1'b0, 32'h0000_004C, 128'h0, 1'b0, lat, d, e, br);
    n_checks++; if (lat !== EXP_LAT) begin n_fail++; $display("FAIL rd_latency got %0d want %0d", lat, EXP_LAT); end
    n_checks++; if (d !== line) begin n_fail++; $display("FAIL rd_data got %h want %h", d, line); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL rd_error got %b want 0", e); end
  endtask

  task automatic test_rw_conflict();
    int lat, br; logic [127:0] d; logic e;
    logic [127:0] base = {32'hA4, 32'hA3, 32'hA2, 32'hA1};
    logic [127:0] junk = {32'hDEAD_0004, 32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001};
    run_req(1'b0, 1'b1, 32'h0000_0080, base, 1'b0, lat, d, e, br);
    run_req(1'b1, 1'b1, 32'h0000_0080, junk, 1'b0, lat, d, e, br);
    n_checks++; if (d !== base) begin n_fail++; $display("FAIL rw_read_wins got %h want %h", d, base); end
    n_checks++; if (lat !== EXP_LAT) begin n_fail++; $display("FAIL rw_latency got %0d want %0d", lat, EXP_LAT); end
    run_req(1'b1, 1'b0, 32'h0000_0080, 128'h0, 1'b0, lat, d, e, br);
    n_checks++; if (d !== base) begin n_fail++; $display("FAIL rw_reread got %h want %h", d, base); end
  endtask

  task automatic test_back_to_back();
    int lat, br, extra; logic [127:0] d; logic e;
    logic [127:0] la = {32'h44, 32'h33, 32'h22, 32'h11};
    logic [127:0] lb = {32'hA4, 32'hA3, 32'hA2, 32'hA1};
    run_req(1'b1, 1'b0, 32'h0000_0040, 128'h0, 1'b1, lat, d, e, br);
    n_checks++; if (lat !== EXP_LAT) begin n_fail++; $display("FAIL b2b_a_latency got %0d want %0d", lat, EXP_LAT); end
    n_checks++; if (d !== la) begin n_fail++; $display("FAIL b2b_a_data got %h want %h", d, la); end
    n_checks++; if (br !== 0) begin n_fail++; $display("FAIL b2b_a_ready_busy got %0d want 0", br); end
    run_req(1'b1, 1'b0, 32'h0000_0080, 128'h0, 1'b0, lat, d, e, br);
    n_checks++; if (lat !== EXP_LAT) begin n_fail++; $display("FAIL b2b_b_latency got %0d want %0d", lat, EXP_LAT); end
    n_checks++; if (d !== lb) begin n_fail++; $display("FAIL b2b_b_data got %h want %h", d, lb); end
    n_checks++; if (br !== 0) begin n_fail++; $display("FAIL b2b_b_ready_busy got %0d want 0", br); end
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) extra++;
    end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL b2b_extra_done got %0d want 0", extra); end
  endtask

  task automatic test_reset_mid_burst();
    int lat, br, seen; logic [127:0] d; logic e;
    logic [127:0] la = {32'h44, 32'h33, 32'h22, 32'h11};
    @(negedge clk);
    rd = 1'b0; wr = 1'b1; addr = 32'h0000_00C0; wdata = {4{32'h5555_AAAA}};
    seen = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      wr = 1'b0;
      if (done) seen++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    if (done) seen++;
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready got %b want 1", ready); end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_done got %0d want 0", seen); end
    rst_n = 1'b1;
    run_req(1'b1, 1'b0, 32'h0000_0044, 128'h0, 1'b0, lat, d, e, br);
    n_checks++; if (lat !== EXP_LAT) begin n_fail++; $display("FAIL abort_next_latency got %0d want %0d", lat, EXP_LAT); end
    n_checks++; if (d !== la) begin n_fail++; $display("FAIL abort_next_data got %h want %h", d, la); end
  endtask

  task automatic test_bounds();
    int lat, br; logic [127:0] d; logic e;
    logic [127:0] l0 = {32'h0D, 32'h0C, 32'h0B, 32'h0A};
    run_req(1'b0, 1'b1, 32'h0000_0000, l0, 1'b0, lat, d, e, br);
    run_req(1'b1, 1'b0, 32'h0001_0000, 128'h0, 1'b0, lat, d, e, br);
    n_checks++; if (lat !== EXP_LAT) begin n_fail++; $display("FAIL bounds_latency got %0d want %0d", lat, EXP_LAT); end
`ifdef MEMORY_BOUNDS_CHECK_EN
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL bounds_error got %b want 1", e); end
    n_checks++; if (d !== 128'h0) begin n_fail++; $display("FAIL bounds_rdata got %h want 0", d); end
`else
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL bounds_error got %b want 0", e); end
    n_checks++; if (d !== l0) begin n_fail++; $display("FAIL bounds_wrap got %h want %h", d, l0); end
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_rw_conflict();
    test_back_to_back();
    test_reset_mid_burst();
    test_bounds();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
